// File: rtl/pid_gain_damper.sv
// Derates PID Kp/Kd by an arithmetic right shift whose level escalates while the
// oscillation flag persists, holds after it clears, then steps back to nominal.
module pid_gain_damper #(
   parameter int GAIN_W        = 32,
   parameter int MAX_LEVEL     = 4,
   parameter int ESC_TICKS     = 200,
   parameter int HOLD_TICKS    = 1000,
   parameter int RECOVER_TICKS = 500
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clk_100k_enable,
   input  logic              enable,
   input  logic              oscillating_flag,
   input  logic [GAIN_W-1:0] kp_in,
   input  logic [GAIN_W-1:0] ki_in,
   input  logic [GAIN_W-1:0] kd_in,
   output logic [GAIN_W-1:0] kp_out,
   output logic [GAIN_W-1:0] ki_out,
   output logic [GAIN_W-1:0] kd_out,
   output logic [2:0]        damp_level,
   output logic              damp_active,
   output logic              damp_saturated
);

   localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
   localparam int ESC_W  = $clog2(ESC_TICKS + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int REC_W  = $clog2(RECOVER_TICKS + 1);

   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LEVEL);
   localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
   localparam logic [ESC_W-1:0]  ESC_LAST  = ESC_W'(ESC_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(RECOVER_TICKS - 1);

   typedef enum logic [1:0] {NOMINAL, DAMPED, RECOVER} state_t;

   state_t             state_q, state_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [ESC_W-1:0]   esc_q,   esc_d;
   logic [HOLD_W-1:0]  hold_q,  hold_d;
   logic [REC_W-1:0]   rec_q,   rec_d;
   logic               active_q, sat_q;
   logic [GAIN_W-1:0]  kp_q, ki_q, kd_q;

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      esc_d   = esc_q;
      hold_d  = hold_q;
      rec_d   = rec_q;
      if (!enable) begin
         state_d = NOMINAL;
         level_d = '0;
         esc_d   = '0;
         hold_d  = '0;
         rec_d   = '0;
      end else if (clk_100k_enable) begin
         case (state_q)
            NOMINAL: begin
               if (oscillating_flag) begin
                  state_d = DAMPED;
                  level_d = LVL_ONE;
                  esc_d   = '0;
                  hold_d  = '0;
               end
            end
            DAMPED: begin
               if (oscillating_flag) begin
                  hold_d = '0;
                  if (esc_q == ESC_LAST) begin
                     esc_d = '0;
                     if (level_q != LVL_MAX) level_d = level_q + 1'b1;
                  end else begin
                     esc_d = esc_q + 1'b1;
                  end
               end else begin
                  esc_d = '0;
                  if (hold_q == HOLD_LAST) begin
                     state_d = RECOVER;
                     hold_d  = '0;
                     rec_d   = '0;
                  end else begin
                     hold_d = hold_q + 1'b1;
                  end
               end
            end
            RECOVER: begin
               if (oscillating_flag) begin
                  state_d = DAMPED;
                  if (level_q != LVL_MAX) level_d = level_q + 1'b1;
                  esc_d  = '0;
                  hold_d = '0;
                  rec_d  = '0;
               end else if (rec_q == REC_LAST) begin
                  rec_d   = '0;
                  level_d = level_q - 1'b1;
                  if (level_q == LVL_ONE) state_d = NOMINAL;
               end else begin
                  rec_d = rec_q + 1'b1;
               end
            end
            default: begin
               state_d = NOMINAL;
               level_d = '0;
               esc_d   = '0;
               hold_d  = '0;
               rec_d   = '0;
            end
         endcase
      end
   end

   // Status flags come from next-state values so they change with the level, not a clk later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= NOMINAL;
         level_q  <= '0;
         esc_q    <= '0;
         hold_q   <= '0;
         rec_q    <= '0;
         active_q <= 1'b0;
         sat_q    <= 1'b0;
         kp_q     <= '0;
         ki_q     <= '0;
         kd_q     <= '0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         esc_q    <= esc_d;
         hold_q   <= hold_d;
         rec_q    <= rec_d;
         active_q <= (state_d != NOMINAL);
         sat_q    <= (level_d == LVL_MAX);
         kp_q     <= $signed(kp_in) >>> level_q;
         ki_q     <= ki_in;
         kd_q     <= $signed(kd_in) >>> level_q;
      end
   end

   assign kp_out         = kp_q;
   assign ki_out         = ki_q;
   assign kd_out         = kd_q;
   assign damp_level     = 3'(level_q);
   assign damp_active    = active_q;
   assign damp_saturated = sat_q;

endmodule

// File: tb/tb_pid_gain_damper.sv
// Scoreboard bench for pid_gain_damper: stimulus queues hand-computed expectations
// tagged with a target cycle; a negedge monitor pops and compares them.
module tb_pid_gain_damper;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick = 1'b0;
   logic        enable = 1'b1;
   logic        osc = 1'b0;
   logic [31:0] kp_in, ki_in, kd_in;
   logic [31:0] kp_out, ki_out, kd_out;
   logic [2:0]  damp_level;
   logic        damp_active, damp_saturated;

   typedef struct {
      int when;
      int kp;
      int ki;
      int kd;
      int lvl;
      bit act;
      bit sat;
   } exp_t;

   exp_t  sb[$];
   string names[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    KP[5] = '{1000, 500, 250, 125, 62};
   int    KD[5] = '{-400, -200, -100, -50, -25};

   pid_gain_damper #(
      .GAIN_W        (32),
      .MAX_LEVEL     (4),
      .ESC_TICKS     (4),
      .HOLD_TICKS    (8),
      .RECOVER_TICKS (3)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .clk_100k_enable  (tick),
      .enable           (enable),
      .oscillating_flag (osc),
      .kp_in            (kp_in),
      .ki_in            (ki_in),
      .kd_in            (kd_in),
      .kp_out           (kp_out),
      .ki_out           (ki_out),
      .kd_out           (kd_out),
      .damp_level       (damp_level),
      .damp_active      (damp_active),
      .damp_saturated   (damp_saturated)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_next(input string nm, input int kp, input int ki, input int kd,
                              input int lvl, input bit act, input bit sat);
      exp_t e;
      e.when = cyc + 1;
      e.kp = kp; e.ki = ki; e.kd = kd;
      e.lvl = lvl; e.act = act; e.sat = sat;
      sb.push_back(e);
      names.push_back(nm);
   endtask

   task automatic step(input bit t);
      tick = t;
      @(negedge clk);
      tick = 1'b0;
   endtask

   // One tick with the given flag, then a quiet clk so gains reflect the new level.
   task automatic tick_chk(input string nm, input bit f, input int lvl, input bit act);
      osc = f;
      step(1'b1);
      expect_next(nm, KP[lvl], 777, KD[lvl], lvl, act, lvl == 4);
      step(1'b0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t  e;
      string nm;
      while (sb.size() > 0 && sb[0].when <= cyc) begin
         e  = sb.pop_front();
         nm = names.pop_front();
         total++;
         if (kp_out !== 32'(e.kp) || ki_out !== 32'(e.ki) || kd_out !== 32'(e.kd) ||
             damp_level !== 3'(e.lvl) || damp_active !== e.act || damp_saturated !== e.sat) begin
            bad++;
            $display("FAIL %s @cyc %0d: got kp=%0d ki=%0d kd=%0d lvl=%0d act=%0b sat=%0b, want kp=%0d ki=%0d kd=%0d lvl=%0d act=%0b sat=%0b",
                     nm, cyc, $signed(kp_out), $signed(ki_out), $signed(kd_out), damp_level,
                     damp_active, damp_saturated, e.kp, e.ki, e.kd, e.lvl, e.act, e.sat);
         end
      end
   end

   initial begin
      kp_in = 32'd1000;
      ki_in = 32'd777;
      kd_in = -32'sd400;
      @(negedge clk);

      expect_next("reset", 0, 0, 0, 0, 1'b0, 1'b0);
      step(1'b0);
      reset_n = 1'b1;
      expect_next("nominal", 1000, 777, -400, 0, 1'b0, 1'b0);
      step(1'b0);
      tick_chk("nominal_tick_flag0", 1'b0, 0, 1'b0);

      // Level moves on the tick edge; gains follow one clk later.
      osc = 1'b1;
      expect_next("enter_lvl1_latency", 1000, 777, -400, 1, 1'b1, 1'b0);
      step(1'b1);
      expect_next("enter_lvl1", 500, 777, -200, 1, 1'b1, 1'b0);
      step(1'b0);

      for (int i = 1; i < 20; i++)
         tick_chk("escalate", 1'b1, (1 + i / 4 > 4) ? 4 : 1 + i / 4, 1'b1);
      for (int j = 1; j <= 8; j++)
         tick_chk("hold_from4", 1'b0, 4, 1'b1);
      for (int r = 1; r <= 12; r++)
         tick_chk("recover", 1'b0, 4 - r / 3, r < 12);

      tick_chk("reenter", 1'b1, 1, 1'b1);
      for (int i = 1; i <= 4; i++)
         tick_chk("esc_to2", 1'b1, (i == 4) ? 2 : 1, 1'b1);
      for (int j = 1; j <= 8; j++)
         tick_chk("hold_at2", 1'b0, 2, 1'b1);
      tick_chk("recover_reflag_lvl2", 1'b1, 3, 1'b1);
      for (int i = 1; i <= 4; i++)
         tick_chk("esc_to4", 1'b1, (i == 4) ? 4 : 3, 1'b1);
      for (int j = 1; j <= 8; j++)
         tick_chk("hold_at4", 1'b0, 4, 1'b1);
      tick_chk("recover_reflag_sat", 1'b1, 4, 1'b1);
      for (int j = 1; j <= 8; j++)
         tick_chk("hold_at4_b", 1'b0, 4, 1'b1);
      for (int r = 1; r <= 3; r++)
         tick_chk("recover_to3", 1'b0, (r == 3) ? 3 : 4, 1'b1);

      enable = 1'b0;
      expect_next("disable_level", 125, 777, -50, 0, 1'b0, 1'b0);
      step(1'b0);
      expect_next("disable_gains", 1000, 777, -400, 0, 1'b0, 1'b0);
      step(1'b0);
      tick_chk("bypass_tick_flag1", 1'b1, 0, 1'b0);
      enable = 1'b1;
      tick_chk("resume", 1'b1, 1, 1'b1);
      for (int i = 1; i <= 8; i++)
         tick_chk("esc_to3", 1'b1, 1 + i / 4, 1'b1);

      #2 reset_n = 1'b0;
      expect_next("async_reset", 0, 0, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      osc = 1'b0;
      expect_next("post_reset", 1000, 777, -400, 0, 1'b0, 1'b0);
      step(1'b0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         $display("FAIL drain: pending=%0d, want 0", sb.size());
         bad += sb.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
